// File: rtl/mult4u_acc_if.sv
// Operand/result handshake bundle for the 4x4 multiply-accumulate block.
interface mult4u_acc_if #(
  parameter int unsigned ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  // Environment side: produces operand pairs and consumes frame results.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  // Block side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mult4u_acc.sv
// Frame-based unsigned 4x4 multiply-accumulate: sums FRAME_LEN products,
// presents the result with a sticky carry-out flag, and waits for the consumer.
module mult4u_acc #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ACC_W     = 12
) (
  input logic         clk,
  input logic         rst,
  mult4u_acc_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned PROD_W = 8;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PROD_W-1:0]  p_q, p_d;
  logic               p_vld_q, p_vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   iss_cnt_q, iss_cnt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept_c;
  logic               hs_c;
  logic               last_acc_c;
  logic [SUM_W-1:0]   sum_ext_c;

  // All state updates on the rising edge; reset is folded into the _d logic.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    p_q         <= p_d;
    p_vld_q     <= p_vld_d;
    acc_q       <= acc_d;
    acc_cnt_q   <= acc_cnt_d;
    iss_cnt_q   <= iss_cnt_d;
    ovf_q       <= ovf_d;
    in_ready_q  <= in_ready_d;
    out_valid_q <= out_valid_d;
  end

  // Handshake decode and the carry-extended accumulate sum.
  always_comb begin
    accept_c   = bus.in_valid && in_ready_q;
    hs_c       = out_valid_q && bus.out_ready;
    last_acc_c = p_vld_q && (acc_cnt_q == CNT_W'(FRAME_LEN - 1));
    sum_ext_c  = {1'b0, acc_q} + SUM_W'(p_q);
  end

  // Next state: leave ACCUM on the final accumulate, leave HOLD on handshake.
  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last_acc_c) state_d = HOLD;
        HOLD:    if (hs_c)       state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Datapath and registered outputs, derived from the next state.
  always_comb begin
    p_d       = p_q;
    p_vld_d   = 1'b0;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    iss_cnt_d = iss_cnt_q;
    ovf_d     = ovf_q;
    if (rst) begin
      p_d       = '0;
      acc_d     = '0;
      acc_cnt_d = '0;
      iss_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (accept_c) begin
        p_d       = PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
        p_vld_d   = 1'b1;
        iss_cnt_d = iss_cnt_q + CNT_W'(1);
      end
      if (p_vld_q) begin
        acc_d     = sum_ext_c[ACC_W-1:0];
        ovf_d     = ovf_q | sum_ext_c[ACC_W];
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
      if (hs_c) begin
        acc_d     = '0;
        acc_cnt_d = '0;
        iss_cnt_d = '0;
        ovf_d     = 1'b0;
      end
    end
    in_ready_d  = (state_d == ACCUM) && (iss_cnt_d < CNT_W'(FRAME_LEN));
    out_valid_d = (state_d == HOLD);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: doc/mult4u_acc.md
MULT4U_ACC -- requirements
Module: mult4u_acc

Interface
REQ-001 Parameter FRAME_LEN, default 4, is the number of operand pairs summed per result; legal range is 1..16.
REQ-002 Parameter ACC_W, default 12, is the accumulator and result width; legal range is 8..16.
REQ-003 clk  input  1  is the single clock, and all state SHALL update on its rising edge.
REQ-004 rst  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  SHALL indicate that the operand pair is valid.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts an operand pair this cycle.
REQ-007 in_a  input  4  SHALL carry the unsigned multiplicand.
REQ-008 in_b  input  4  SHALL carry the unsigned multiplier.
REQ-009 out_valid  output  1  SHALL indicate that the frame result is valid.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-011 out_sum  output  ACC_W  SHALL carry the sum of FRAME_LEN products, modulo 2^ACC_W.
REQ-012 out_ovf  output  1  SHALL be set when any accumulation in the frame carried out of ACC_W bits.

Function
REQ-013 The block SHALL accept an input only when in_valid=1 and in_ready=1 in the same cycle.
REQ-014 Stage 1: on accept, the block SHALL register the 8-bit unsigned product in_a*in_b into p_reg and set p_vld=1 in the next cycle; otherwise p_vld=0.
REQ-015 Stage 2: when p_vld=1, the block SHALL update acc <= acc + p_reg, truncated to ACC_W bits, and increment acc_cnt.
REQ-016 If that addition carries out of ACC_W bits, the block SHALL set a sticky ovf flag for the frame.
REQ-017 The block SHALL count accepted pairs in iss_cnt, which spans 0..FRAME_LEN.
REQ-018 in_ready SHALL equal (state==ACCUM) and (iss_cnt<FRAME_LEN).
REQ-019 The state machine SHALL have two states: ACCUM and HOLD.
REQ-020 ACCUM -> HOLD SHALL occur on the edge where stage 2 accumulates the product with acc_cnt==FRAME_LEN-1.
REQ-021 In HOLD, out_valid SHALL be 1, out_sum SHALL equal acc, and out_ovf SHALL equal ovf.
REQ-022 In ACCUM, out_valid SHALL be 0.
REQ-023 In HOLD with out_ready=0, out_sum and out_ovf SHALL remain stable and in_ready SHALL remain 0.
REQ-024 HOLD -> ACCUM SHALL occur on out_valid&out_ready, and on that edge acc, acc_cnt, iss_cnt and ovf SHALL clear to 0.
REQ-025 in_ready SHALL be 1 in the cycle after the output handshake.
REQ-026 Latency from accept of the last pair of a frame to out_valid=1 SHALL be exactly 2 cycles.
REQ-027 Gaps in in_valid SHALL only stall the frame; they SHALL not alter the sum or the count.
REQ-028 With FRAME_LEN=1, a single accepted pair SHALL produce out_valid 2 cycles later.
REQ-029 in_a and in_b SHALL be ignored whenever in_ready=0 or in_valid=0.
REQ-030 out_ready SHALL be ignored in ACCUM.
REQ-031 Product arithmetic SHALL be exact unsigned 4x4->8 (maximum 225), with no approximation.

Reset
REQ-032 While rst=1, state SHALL become ACCUM, and acc, acc_cnt, iss_cnt, p_reg, p_vld and ovf SHALL become 0, effective on the next edge.
REQ-033 After reset, outputs SHALL be in_ready=1, out_valid=0, out_sum=0 and out_ovf=0.
REQ-034 If rst is asserted mid-frame or in HOLD, the partial frame SHALL be discarded and not emitted.
REQ-035 If rst=1 coincides with an accept or an output handshake, rst SHALL take priority.

Verification
REQ-036 Full-scale case: with defaults, 4 pairs (15,15) on consecutive cycles -> out_valid 2 cycles after the 4th accept, out_sum=900, out_ovf=0.
REQ-037 Mixed values with gaps: defaults, pairs (3,5),(0,9),(7,7),(1,1) with an idle cycle between each -> out_sum=65, in_ready=0 after the 4th accept until the output handshake.
REQ-038 Back-pressure: hold out_ready=0 for 5 cycles in HOLD -> out_sum stays stable, in_ready=0; handshake on cycle 6 -> in_ready=1 next cycle, next frame starts from 0.
REQ-039 Overflow: with ACC_W=8 and FRAME_LEN=2, pairs (15,15),(15,15) -> out_sum=194, out_ovf=1; the following frame (1,1),(2,2) -> out_sum=5, out_ovf=0.
REQ-040 Reset mid-frame: with defaults, accept (15,15) twice, assert rst for 1 cycle, then send 4 pairs (1,2) -> a single out_valid with out_sum=8.
REQ-041 Single-pair frame: with FRAME_LEN=1, pair (15,14) -> out_sum=210 two cycles after accept, in_ready=0 until the handshake.
